// File: rtl/conv_window_gen_if.sv
// Pixel-stream in / K-tap window out bundle for conv_window_gen.
// master is the stream producer/consumer side, slave is the window generator.
interface conv_window_gen_if #(
    parameter int data_width = 32,
    parameter int K          = 7
);
    logic                    valid_in;
    logic [data_width-1:0]   pxl_in;
    logic                    in_ready;
    logic [K*data_width-1:0] pxl_win;
    logic                    valid_out;
    logic                    frame_done;

    modport master (
        output valid_in, pxl_in,
        input  in_ready, pxl_win, valid_out, frame_done
    );

    modport slave (
        input  valid_in, pxl_in,
        output in_ready, pxl_win, valid_out, frame_done
    );
endinterface

// File: rtl/conv_window_gen.sv
// Streaming 1xK / Kx1 window generator with "same" padding over one DxD plane.
// Emits one K-tap window per pixel, centred on it, out-of-image taps set to PAD.
module conv_window_gen #(
    parameter int                    data_width = 32,
    parameter int                    D          = 17,
    parameter int                    K          = 7,
    parameter int                    MODE       = 0,
    parameter logic [data_width-1:0] PAD        = '0
) (
    input  logic             clk,
    input  logic             reset,
    conv_window_gen_if.slave bus
);
    localparam int S     = (MODE == 1) ? D : 1;
    localparam int P     = (K - 1) / 2;
    localparam int L     = P * S;
    localparam int T     = D * D;
    localparam int N     = (K - 1) * S + 1;
    localparam int CNT_W = $clog2(T);
    localparam int POS_W = $clog2(D);

    localparam logic [CNT_W-1:0] CNT_T_LAST = CNT_W'(T - 1);
    localparam logic [CNT_W-1:0] CNT_L_LAST = CNT_W'(L - 1);
    localparam logic [POS_W-1:0] POS_LAST   = POS_W'(D - 1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              in_cnt_q, in_cnt_d;
    logic [POS_W-1:0]              r_o_q, r_o_d;
    logic [POS_W-1:0]              c_o_q, c_o_d;
    // The newest word is taken straight from the input, so only N-1 words are held.
    logic [N-2:0][data_width-1:0]  sr_q, sr_d;
    logic [N-1:0][data_width-1:0]  line_s;
    logic [K*data_width-1:0]       win_q, win_d;
    logic                          valid_q, valid_d;
    logic                          done_q, done_d;
    logic                          rdy_q, rdy_d;
    logic                          accept_s, shift_s, emit_s, last_s;
    logic [data_width-1:0]         shift_val_s;

    function automatic logic tap_in_image(input logic [POS_W-1:0] pos, input int j);
        int coord;
        coord = int'(pos) + j - P;
        return (coord >= 0) && (coord < D);
    endfunction

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_FILL;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL:  if (accept_s && (in_cnt_q == CNT_L_LAST)) state_d = ST_RUN;   else state_d = ST_FILL;
            ST_RUN:   if (accept_s && (in_cnt_q == CNT_T_LAST)) state_d = ST_FLUSH; else state_d = ST_RUN;
            ST_FLUSH: if (in_cnt_q == CNT_L_LAST)               state_d = ST_FILL;  else state_d = ST_FLUSH;
            default:  state_d = ST_FILL;
        endcase
    end

    // FSM outputs: shift/emit strobes and the word entering the line.
    always_comb begin
        accept_s    = bus.valid_in & rdy_q;
        shift_s     = 1'b0;
        emit_s      = 1'b0;
        last_s      = 1'b0;
        shift_val_s = bus.pxl_in;
        case (state_q)
            ST_FILL: shift_s = accept_s;
            ST_RUN: begin
                shift_s = accept_s;
                emit_s  = accept_s;
            end
            ST_FLUSH: begin
                shift_s     = 1'b1;
                emit_s      = 1'b1;
                shift_val_s = PAD;
                last_s      = (in_cnt_q == CNT_L_LAST);
            end
            default: shift_s = 1'b0;
        endcase
    end

    // Datapath: line shift, counters, masked window.
    always_comb begin
        line_s   = {sr_q, shift_val_s};
        sr_d     = sr_q;
        in_cnt_d = in_cnt_q;
        r_o_d    = r_o_q;
        c_o_d    = c_o_q;
        win_d    = win_q;
        valid_d  = emit_s;
        done_d   = last_s;
        rdy_d    = (state_d != ST_FLUSH);
        if (shift_s) begin
            sr_d = line_s[N-2:0];
            // FILL hands its count over to RUN; RUN->FLUSH and FLUSH->FILL restart it.
            if ((state_q != ST_FILL) && (state_d != state_q)) in_cnt_d = '0;
            else                                               in_cnt_d = in_cnt_q + CNT_W'(1);
        end else begin
            sr_d = sr_q;
        end
        if (emit_s) begin
            for (int j = 0; j < K; j++) begin
                if (tap_in_image((MODE == 1) ? r_o_q : c_o_q, j))
                    win_d[j*data_width +: data_width] = line_s[(K - 1 - j) * S];
                else
                    win_d[j*data_width +: data_width] = PAD;
            end
            if (c_o_q == POS_LAST) begin
                c_o_d = '0;
                if (r_o_q == POS_LAST) r_o_d = '0;
                else                   r_o_d = r_o_q + POS_W'(1);
            end else begin
                c_o_d = c_o_q + POS_W'(1);
            end
        end else begin
            win_d = win_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q     <= '0;
            in_cnt_q <= '0;
            r_o_q    <= '0;
            c_o_q    <= '0;
            win_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            in_cnt_q <= in_cnt_d;
            r_o_q    <= r_o_d;
            c_o_q    <= c_o_d;
            win_q    <= win_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            rdy_q    <= rdy_d;
        end
    end

    assign bus.in_ready   = rdy_q;
    assign bus.pxl_win    = win_q;
    assign bus.valid_out  = valid_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: three configurations checked against
// a coordinate-based window model with random pixels and random stalls.
module tb_conv_window_gen;
    localparam logic [31:0] PADV = 32'hA5A5_5A5A;

    logic         clk;
    logic         reset;
    logic         vin    [3];
    logic [31:0]  pin    [3];
    logic         rdy_w  [3];
    logic         vout_w [3];
    logic         done_w [3];
    logic [223:0] win_w  [3];

    logic [31:0]  pix     [289];
    logic [223:0] obs_win [289];
    logic [223:0] ref_s1  [25];
    int n_cmp;
    int n_fail;

    conv_window_gen_if #(.data_width(32), .K(3)) if0 ();
    conv_window_gen_if #(.data_width(32), .K(3)) if1 ();
    conv_window_gen_if #(.data_width(32), .K(7)) if2 ();

    assign if0.valid_in = vin[0];
    assign if1.valid_in = vin[1];
    assign if2.valid_in = vin[2];
    assign if0.pxl_in   = pin[0];
    assign if1.pxl_in   = pin[1];
    assign if2.pxl_in   = pin[2];
    assign rdy_w[0]  = if0.in_ready;
    assign rdy_w[1]  = if1.in_ready;
    assign rdy_w[2]  = if2.in_ready;
    assign vout_w[0] = if0.valid_out;
    assign vout_w[1] = if1.valid_out;
    assign vout_w[2] = if2.valid_out;
    assign done_w[0] = if0.frame_done;
    assign done_w[1] = if1.frame_done;
    assign done_w[2] = if2.frame_done;
    assign win_w[0]  = {128'b0, if0.pxl_win};
    assign win_w[1]  = {128'b0, if1.pxl_win};
    assign win_w[2]  = if2.pxl_win;

    conv_window_gen #(.data_width(32), .D(5), .K(3), .MODE(0), .PAD(PADV))
        dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    conv_window_gen #(.data_width(32), .D(5), .K(3), .MODE(1), .PAD(PADV))
        dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    conv_window_gen #(.data_width(32), .D(17), .K(7), .MODE(1), .PAD(32'h0000_0000))
        dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cfg_d(input int id);
        return (id == 2) ? 17 : 5;
    endfunction
    function automatic int cfg_k(input int id);
        return (id == 2) ? 7 : 3;
    endfunction
    function automatic int cfg_mode(input int id);
        return (id == 0) ? 0 : 1;
    endfunction
    function automatic logic [31:0] cfg_pad(input int id);
        return (id == 2) ? 32'h0000_0000 : PADV;
    endfunction

    // Window for output pixel n: taps along a row (mode 0) or column (mode 1).
    function automatic logic [223:0] model_win(input int id, input int n);
        int d, k, p, r, c, rr, cc;
        logic [223:0] w;
        d = cfg_d(id); k = cfg_k(id); p = (k - 1) / 2;
        r = n / d; c = n % d;
        w = '0;
        for (int j = 0; j < k; j++) begin
            if (cfg_mode(id) == 0) begin rr = r; cc = c - p + j; end
            else                   begin rr = r - p + j; cc = c; end
            if (rr < 0 || rr >= d || cc < 0 || cc >= d) w[j*32 +: 32] = cfg_pad(id);
            else                                        w[j*32 +: 32] = pix[rr*d + cc];
        end
        return w;
    endfunction

    function automatic logic [223:0] pack3(input logic [31:0] t0, input logic [31:0] t1,
                                           input logic [31:0] t2);
        logic [223:0] w;
        w = '0;
        w[95:0] = {t2, t1, t0};
        return w;
    endfunction

    // Drives one frame of pix[] into instance id (smode: 0 none, 1 alternate, 2 random stalls).
    task automatic drive_frame(input int id, input int smode, input bit hold);
        int d, t, l, ns, nwin, nlow;
        logic [223:0] exp_w;
        d = cfg_d(id); t = d * d;
        l = ((cfg_k(id) - 1) / 2) * ((cfg_mode(id) == 1) ? d : 1);
        nwin = 0; nlow = 0;
        for (int i = 0; i < t; i++) begin
            ns = 0;
            if (smode == 1 && i > 0) ns = 1;
            else if (smode == 2 && $urandom_range(2, 0) == 0) ns = int'($urandom_range(3, 1));
            for (int s = 0; s < ns; s++) begin
                vin[id] = 1'b0;
                @(posedge clk); #1;
                n_cmp++;
                if (vout_w[id] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_no_output id=%0d in=%0d got=%b want=0", id, i, vout_w[id]);
                end
            end
            n_cmp++;
            if (rdy_w[id] !== 1'b1) begin
                n_fail++;
                $display("FAIL in_ready_accept id=%0d in=%0d got=%b want=1", id, i, rdy_w[id]);
            end
            vin[id] = 1'b1; pin[id] = pix[i];
            @(posedge clk); #1;
            if (vout_w[id] === 1'b1) nwin++;
            if (i >= l) begin
                exp_w = model_win(id, i - l);
                obs_win[i - l] = win_w[id];
                n_cmp++;
                if (vout_w[id] !== 1'b1 || done_w[id] !== 1'b0 || win_w[id] !== exp_w) begin
                    n_fail++;
                    $display("FAIL run_window id=%0d out=%0d valid=%b done=%b got=%h want=%h",
                             id, i - l, vout_w[id], done_w[id], win_w[id], exp_w);
                end
            end else begin
                n_cmp++;
                if (vout_w[id] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_no_output id=%0d in=%0d got=%b want=0", id, i, vout_w[id]);
                end
            end
        end
        vin[id] = hold;
        for (int f = 0; f < l; f++) begin
            if (rdy_w[id] === 1'b0) nlow++;
            pin[id] = $urandom;
            @(posedge clk); #1;
            if (vout_w[id] === 1'b1) nwin++;
            exp_w = model_win(id, t - l + f);
            obs_win[t - l + f] = win_w[id];
            n_cmp++;
            if (vout_w[id] !== 1'b1 || done_w[id] !== (f == l - 1) || win_w[id] !== exp_w) begin
                n_fail++;
                $display("FAIL flush_window id=%0d out=%0d valid=%b done=%b got=%h want=%h",
                         id, t - l + f, vout_w[id], done_w[id], win_w[id], exp_w);
            end
        end
        n_cmp++;
        if (nlow != l || rdy_w[id] !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ready id=%0d low_cycles=%0d ready_after=%b want %0d and 1",
                     id, nlow, rdy_w[id], l);
        end
        n_cmp++;
        if (nwin != t) begin
            n_fail++;
            $display("FAIL window_count id=%0d got=%0d want=%0d", id, nwin, t);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        for (int id = 0; id < 3; id++) begin
            n_cmp++;
            if (vout_w[id] !== 1'b0 || done_w[id] !== 1'b0 || rdy_w[id] !== 1'b0 || win_w[id] !== '0) begin
                n_fail++;
                $display("FAIL reset_state id=%0d valid=%b done=%b ready=%b win=%h want all 0",
                         id, vout_w[id], done_w[id], rdy_w[id], win_w[id]);
            end
        end
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        for (int id = 0; id < 3; id++) begin
            n_cmp++;
            if (rdy_w[id] !== 1'b1) begin
                n_fail++;
                $display("FAIL ready_after_reset id=%0d got=%b want=1", id, rdy_w[id]);
            end
        end
    endtask

    task automatic test_mode0_basic;
        for (int i = 0; i < 25; i++) pix[i] = 32'(i + 1);
        drive_frame(0, 0, 1'b0);
        n_cmp++;
        if (obs_win[0] !== pack3(PADV, 32'd1, 32'd2)) begin
            n_fail++; $display("FAIL m0_win00 got=%h want=%h", obs_win[0], pack3(PADV, 32'd1, 32'd2));
        end
        n_cmp++;
        if (obs_win[4] !== pack3(32'd4, 32'd5, PADV)) begin
            n_fail++; $display("FAIL m0_win04 got=%h want=%h", obs_win[4], pack3(32'd4, 32'd5, PADV));
        end
        n_cmp++;
        if (obs_win[5] !== pack3(PADV, 32'd6, 32'd7)) begin
            n_fail++; $display("FAIL m0_win10 got=%h want=%h", obs_win[5], pack3(PADV, 32'd6, 32'd7));
        end
        n_cmp++;
        if (obs_win[24] !== pack3(32'd24, 32'd25, PADV)) begin
            n_fail++; $display("FAIL m0_win44 got=%h want=%h", obs_win[24], pack3(32'd24, 32'd25, PADV));
        end
        for (int i = 0; i < 25; i++) ref_s1[i] = obs_win[i];
    endtask

    task automatic test_mode1_basic;
        for (int i = 0; i < 25; i++) pix[i] = 32'(i + 1);
        drive_frame(1, 0, 1'b0);
        n_cmp++;
        if (obs_win[0] !== pack3(PADV, 32'd1, 32'd6)) begin
            n_fail++; $display("FAIL m1_win00 got=%h want=%h", obs_win[0], pack3(PADV, 32'd1, 32'd6));
        end
        n_cmp++;
        if (obs_win[12] !== pack3(32'd8, 32'd13, 32'd18)) begin
            n_fail++; $display("FAIL m1_win22 got=%h want=%h", obs_win[12], pack3(32'd8, 32'd13, 32'd18));
        end
        n_cmp++;
        if (obs_win[24] !== pack3(32'd20, 32'd25, PADV)) begin
            n_fail++; $display("FAIL m1_win44 got=%h want=%h", obs_win[24], pack3(32'd20, 32'd25, PADV));
        end
    endtask

    task automatic test_stalls;
        for (int pass = 1; pass <= 2; pass++) begin
            for (int i = 0; i < 25; i++) pix[i] = 32'(i + 1);
            drive_frame(0, pass, 1'b0);
            for (int i = 0; i < 25; i++) begin
                n_cmp++;
                if (obs_win[i] !== ref_s1[i]) begin
                    n_fail++;
                    $display("FAIL stall_same_seq pass=%0d out=%0d got=%h want=%h", pass, i, obs_win[i], ref_s1[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 25; i++) pix[i] = 32'(i + 1);
        drive_frame(0, 0, 1'b1);
        for (int i = 0; i < 25; i++) pix[i] = 32'(i + 101);
        drive_frame(0, 0, 1'b0);
        n_cmp++;
        if (obs_win[0] !== pack3(PADV, 32'd101, 32'd102)) begin
            n_fail++;
            $display("FAIL b2b_first got=%h want=%h", obs_win[0], pack3(PADV, 32'd101, 32'd102));
        end
    endtask

    task automatic test_reset_mid_frame;
        for (int i = 0; i < 25; i++) pix[i] = 32'(i + 1);
        for (int i = 0; i < 12; i++) begin
            vin[0] = 1'b1; pin[0] = pix[i];
            @(posedge clk); #1;
        end
        n_cmp++;
        if (vout_w[0] !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_valid got=%b want=1", vout_w[0]);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (vout_w[0] !== 1'b0 || done_w[0] !== 1'b0 || rdy_w[0] !== 1'b0 || win_w[0] !== '0) begin
            n_fail++;
            $display("FAIL async_reset valid=%b done=%b ready=%b win=%h want all 0",
                     vout_w[0], done_w[0], rdy_w[0], win_w[0]);
        end
        vin[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (rdy_w[0] !== 1'b1 || vout_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset ready=%b valid=%b want 1 and 0", rdy_w[0], vout_w[0]);
        end
        drive_frame(0, 0, 1'b0);
        for (int i = 0; i < 25; i++) begin
            n_cmp++;
            if (obs_win[i] !== ref_s1[i]) begin
                n_fail++;
                $display("FAIL reset_replay out=%0d got=%h want=%h", i, obs_win[i], ref_s1[i]);
            end
        end
    endtask

    task automatic test_defaults;
        logic [223:0] e;
        for (int i = 0; i < 289; i++) pix[i] = $urandom;
        drive_frame(2, 2, 1'b0);
        e = '0;
        e[3*32 +: 32] = pix[0];  e[4*32 +: 32] = pix[17];
        e[5*32 +: 32] = pix[34]; e[6*32 +: 32] = pix[51];
        n_cmp++;
        if (obs_win[0] !== e) begin
            n_fail++; $display("FAIL def_win00 got=%h want=%h", obs_win[0], e);
        end
        e = '0;
        e[0*32 +: 32] = pix[237]; e[1*32 +: 32] = pix[254];
        e[2*32 +: 32] = pix[271]; e[3*32 +: 32] = pix[288];
        n_cmp++;
        if (obs_win[288] !== e) begin
            n_fail++; $display("FAIL def_win_last got=%h want=%h", obs_win[288], e);
        end
    endtask

    task automatic test_random;
        for (int rep = 0; rep < 4; rep++) begin
            for (int i = 0; i < 25; i++) pix[i] = $urandom;
            drive_frame(rep % 2, 2, rep[1]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b0;
        for (int id = 0; id < 3; id++) begin
            vin[id] = 1'b0;
            pin[id] = 32'h0000_0000;
        end
        test_reset();
        test_mode0_basic();
        test_mode1_basic();
        test_stalls();
        test_back_to_back();
        test_reset_mid_frame();
        test_defaults();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Parametrised streaming window generator for separable 1xK / Kx1 convolution branches of the Inception-ResNet blocks.
- Accepts a raster-order pixel stream of one DxD channel plane and emits, one per pixel, the K-tap window centred on that pixel, with "same" padding.
- Sits between the previous stage's pxl_out/valid_out and a K-tap MAC.
- Treats pixels as opaque data_width-bit words; no arithmetic is done on pixel values.

Parameters:
- data_width, 32: pixel word width.
- D, 17: image side length; a frame is T = D*D pixels.
- K, 7: window length. Must be odd and satisfy 3 <= K <= D.
- MODE, 0: window orientation. 0 = horizontal 1xK (tap spacing S=1); 1 = vertical Kx1 (tap spacing S=D).
- PAD, 0: padding word used for out-of-image taps.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-low reset.
- valid_in, input, 1: pxl_in valid this cycle.
- pxl_in, input, data_width: input pixel, raster order.
- in_ready, output, 1: block can accept input. Low during FLUSH and while reset is asserted.
- pxl_win, output, K*data_width: window. Tap j occupies bits [j*data_width +: data_width]; tap 0 is at the LSBs.
- valid_out, output, 1: pxl_win valid this cycle.
- frame_done, output, 1: one-cycle pulse coincident with the last window of a frame.

Behaviour:
- Derived constants: P = (K-1)/2; L = P*S (latency in pixels).
- Storage: shift register of (K-1)*S+1 words; taps read at offsets 0, S, ..., (K-1)*S.
- Input counter in_cnt runs 0..T-1. Output position counters r_o/c_o run over 0..D-1.
- Accept rule: an input is accepted when valid_in && in_ready at the clock edge. When valid_in is low, all state holds and no output is produced.
- Window content for output pixel (r,c), tap j:
  - MODE 0: pixel (r, c-P+j).
  - MODE 1: pixel (r-P+j, c).
  - Any tap whose coordinate falls outside 0..D-1 is replaced by PAD. Masking is driven by r_o/c_o, never by stale storage contents.
- FSM:
  - FILL: accept inputs 0..L-1; no outputs. After the L-th accept, go to RUN.
  - RUN: each accept shifts in pxl_in and registers the window for output pixel (in_cnt-L). After accepting input T-1, go to FLUSH.
  - FLUSH: in_ready=0. Runs exactly L cycles; each cycle shifts in PAD and emits one window. valid_in is ignored. On the final flush cycle, frame_done=1 together with valid_out. Then go to FILL with counters cleared.
- Latency: output n is registered at the edge that accepts input n+L (or the matching flush edge), so valid_out is high in the following cycle.
- Throughput: one window per accepted input. A frame of T inputs yields exactly T windows.
- Outputs are registered. valid_out and frame_done are high for exactly one cycle per window.
- Reset (asynchronous, active-low, may occur mid-frame):
  - pxl_win=0, valid_out=0, frame_done=0, in_ready=0.
  - FSM returns to FILL; all counters are cleared.
  - in_ready=1 from the first clock after reset is released.
  - No partial-frame output may appear after reset.

Test Plan:
- MODE=0, D=5, K=3, inputs valued 1..25 with continuous valid_in:
  - No output after input 1.
  - First window {PAD,1,2} appears after input 2.
  - Window (0,4) = {4,5,PAD}, triggered by the input valued 6.
  - Window (1,0) = {PAD,6,7}.
  - 25 windows total; the last, {24,25,PAD}, comes in the single flush cycle with frame_done=1, and in_ready is low for exactly 1 cycle.
- MODE=1, D=5, K=3, inputs 1..25:
  - First window {PAD,1,6} appears after the input valued 6.
  - Window (2,2) = {8,13,18}.
  - in_ready is low for 5 flush cycles.
  - Last window is {20,25,PAD} with frame_done=1.
- Repeat scenario 1 with valid_in toggling 1,0,1,0 and random stalls: the window sequence must be bit-identical, each window appearing one cycle after its triggering accept, with no valid_out during stalls.
- Back-to-back frames (frame 2 valued 101..125), with valid_in held high through FLUSH:
  - Flush cycles accept nothing.
  - First window of frame 2 is {PAD,101,102}.
  - No frame-1 data appears in any frame-2 window.
- Assert reset after 12 accepted inputs:
  - Outputs go to 0 asynchronously.
  - After release, a fresh frame 1..25 reproduces scenario 1 exactly.
- Defaults (D=17, K=7, MODE=1):
  - First valid_out after the 52nd accepted input.
  - 51 flush cycles.
  - 289 windows total.
  - Window (0,0) = {PAD,PAD,PAD,p0,p17,p34,p51}, where pN is the N-th input pixel.
